// File: rtl/jam_cost_table.sv
// Cost-matrix feeder for the JAM assignment engine: streams in an 8x8 cost table,
// holds JAM in reset until the table is complete, then serves W/J lookups.
module jam_cost_table #(
    parameter int DW         = 7,
    parameter int ARM_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [DW-1:0] Cost,
    output logic          jam_rst,
    input  logic          jam_valid,
    output logic          loaded,
    output logic          load_err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ARM   = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES - 1);

    state_t          state, state_nxt;
    logic [5:0]      wcnt, wcnt_nxt;
    logic [3:0]      arm_cnt, arm_nxt;
    logic            err_nxt;
    logic            wr_en;
    logic            accept;
    logic            last_word;
    logic            frame_err;
    logic [DW-1:0]   mem [64];

    assign accept    = in_valid & in_ready;
    assign last_word = (wcnt == 6'd63);
    // in_last must coincide exactly with slot 63; either mismatch restarts the frame
    assign frame_err = in_last ^ last_word;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        arm_nxt   = arm_cnt;
        err_nxt   = load_err;
        wr_en     = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (frame_err) begin
                        wcnt_nxt = 6'd0;
                        err_nxt  = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (wcnt == 6'd0)
                            err_nxt = 1'b0;
                        if (last_word) begin
                            wcnt_nxt  = 6'd0;
                            state_nxt = ARM;
                        end else begin
                            wcnt_nxt = wcnt + 6'd1;
                        end
                    end
                end
            end
            ARM: begin
                if (arm_cnt == ARM_LAST) begin
                    arm_nxt   = 4'd0;
                    state_nxt = SERVE;
                end else begin
                    arm_nxt = arm_cnt + 4'd1;
                end
            end
            SERVE: begin
                if (jam_valid)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Handshake/reset outputs decode the next state so they are glitch-free flops
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= LOAD;
            wcnt     <= 6'd0;
            arm_cnt  <= 4'd0;
            load_err <= 1'b0;
            in_ready <= 1'b1;
            jam_rst  <= 1'b1;
            loaded   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            arm_cnt  <= arm_nxt;
            load_err <= err_nxt;
            in_ready <= (state_nxt == LOAD);
            jam_rst  <= (state_nxt != SERVE);
            loaded   <= (state_nxt == SERVE);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wcnt] <= in_data;
    end

    // JAM's init sweep reads the table while still in reset, so ARM serves too
    assign Cost = (state == ARM || state == SERVE) ? mem[{W, J}] : '0;

endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: loads matrices, checks framing, lookups and re-arm.
module tb_jam_cost_table;

    logic       CLK, RST_n;
    logic       in_valid, in_ready, in_last;
    logic [6:0] in_data;
    logic [2:0] W, J;
    logic [6:0] Cost;
    logic       jam_rst, jam_valid, loaded, load_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] sb[$];
    logic [6:0] expv;

    jam_cost_table #(.DW(7), .ARM_CYCLES(2)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .W(W), .J(J), .Cost(Cost),
        .jam_rst(jam_rst), .jam_valid(jam_valid),
        .loaded(loaded), .load_err(load_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one word and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic send_word(input logic [6:0] d, input logic last, input bit rnd);
        bit acc;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(posedge CLK); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL handshake_timeout in_ready=%0b required=1", in_ready);
        end
    endtask

    // mode 0: (i%100), 1: random, 2: 63-i. Expected words pushed as driven.
    task automatic load_frame(input bit rnd, input int mode, input int first);
        logic [6:0] v;
        for (int i = first; i < 64; i++) begin
            case (mode)
                0:       v = 7'(i % 100);
                1:       v = 7'($urandom_range(0, 127));
                default: v = 7'(63 - i);
            endcase
            sb.push_back(v);
            send_word(v, (i == 63), rnd);
        end
    endtask

    task automatic pulse_jam_valid();
        jam_valid = 1'b1;
        @(posedge CLK); #1;
        jam_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_checks++;
        if (in_ready !== 1'b1 || jam_rst !== 1'b1 || loaded !== 1'b0 || load_err !== 1'b0 || Cost !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_initial rdy=%0b rst=%0b ld=%0b err=%0b cost=%0d required 1 1 0 0 0",
                     in_ready, jam_rst, loaded, load_err, Cost);
        end
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) send_word(7'(i), 1'b0, 1'b0);
        send_word(7'd3, 1'b1, 1'b0);
        @(negedge CLK);
        n_checks++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_err load_err=%0b required=1", load_err);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 5; i++) send_word(7'(i + 20), 1'b0, 1'b0);
        W = 3'd2; J = 3'd1;
        #2;
        RST_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
        n_checks++;
        if (jam_rst !== 1'b1) begin n_fail++; $display("FAIL reset_jam_rst got=%0b required=1", jam_rst); end
        n_checks++;
        if (loaded !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got=%0b required=0", loaded); end
        n_checks++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got=%0b required=0", load_err); end
        n_checks++;
        if (Cost !== 7'd0) begin n_fail++; $display("FAIL reset_cost got=%0d required=0", Cost); end
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        sb.delete();
        load_frame(1'b0, 0, 0);
        W = 3'd5; J = 3'd3;
        @(negedge CLK);
        n_checks++;
        if (in_ready !== 1'b0 || jam_rst !== 1'b1 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL load_arm1 rdy=%0b rst=%0b ld=%0b required 0 1 0", in_ready, jam_rst, loaded);
        end
        n_checks++;
        if (Cost !== 7'd43) begin n_fail++; $display("FAIL load_arm_cost got=%0d required=43", Cost); end
        @(negedge CLK);
        n_checks++;
        if (jam_rst !== 1'b1 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL load_arm2 rst=%0b ld=%0b required 1 0", jam_rst, loaded);
        end
        @(negedge CLK);
        n_checks++;
        if (jam_rst !== 1'b0 || loaded !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_serve rst=%0b ld=%0b rdy=%0b required 0 1 0", jam_rst, loaded, in_ready);
        end
        @(posedge CLK); #1;
        W = 3'd7; J = 3'd7;
        #1;
        n_checks++;
        if (Cost !== 7'd63) begin n_fail++; $display("FAIL load_cost77 got=%0d required=63", Cost); end
        for (int i = 0; i < 64; i++) begin
            {W, J} = 6'(i);
            @(negedge CLK);
            expv = sb.pop_front();
            n_checks++;
            if (Cost !== expv) begin n_fail++; $display("FAIL load_sweep idx=%0d got=%0d required=%0d", i, Cost, expv); end
            @(posedge CLK); #1;
        end
        pulse_jam_valid();
        @(negedge CLK);
        n_checks++;
        if (in_ready !== 1'b1 || jam_rst !== 1'b1 || loaded !== 1'b0 || Cost !== 7'd0) begin
            n_fail++;
            $display("FAIL load_rearm rdy=%0b rst=%0b ld=%0b cost=%0d required 1 1 0 0", in_ready, jam_rst, loaded, Cost);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_random_valid();
        sb.delete();
        load_frame(1'b1, 1, 0);
        in_valid = 1'b1;
        in_data  = 7'h55;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_no_accept cyc=%0d in_ready=%0b required=0", c, in_ready); end
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        n_checks++;
        if (loaded !== 1'b1) begin n_fail++; $display("FAIL rnd_loaded got=%0b required=1", loaded); end
        for (int i = 0; i < 64; i++) begin
            {W, J} = 6'(i);
            @(negedge CLK);
            expv = sb.pop_front();
            n_checks++;
            if (Cost !== expv) begin n_fail++; $display("FAIL rnd_sweep idx=%0d got=%0d required=%0d", i, Cost, expv); end
            @(posedge CLK); #1;
        end
        pulse_jam_valid();
    endtask

    task automatic test_early_last();
        sb.delete();
        for (int i = 0; i < 10; i++) send_word(7'(i + 100), 1'b0, 1'b0);
        send_word(7'd110, 1'b1, 1'b0);
        @(negedge CLK);
        n_checks++;
        if (load_err !== 1'b1 || in_ready !== 1'b1 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err err=%0b rdy=%0b ld=%0b required 1 1 0", load_err, in_ready, loaded);
        end
        @(posedge CLK); #1;
        sb.push_back(7'd63);
        send_word(7'd63, 1'b0, 1'b0);
        @(negedge CLK);
        n_checks++;
        if (load_err !== 1'b0) begin n_fail++; $display("FAIL early_err_clear got=%0b required=0", load_err); end
        @(posedge CLK); #1;
        load_frame(1'b0, 2, 1);
        repeat (3) @(negedge CLK);
        n_checks++;
        if (loaded !== 1'b1 || jam_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL early_serve ld=%0b rst=%0b required 1 0", loaded, jam_rst);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 64; i++) begin
            {W, J} = 6'(i);
            @(negedge CLK);
            expv = sb.pop_front();
            n_checks++;
            if (Cost !== expv) begin n_fail++; $display("FAIL early_sweep idx=%0d got=%0d required=%0d", i, Cost, expv); end
            @(posedge CLK); #1;
        end
        pulse_jam_valid();
    endtask

    task automatic test_missing_last();
        sb.delete();
        for (int i = 0; i < 64; i++) send_word(7'(i), 1'b0, 1'b0);
        @(negedge CLK);
        n_checks++;
        if (load_err !== 1'b1 || in_ready !== 1'b1 || jam_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_err err=%0b rdy=%0b rst=%0b required 1 1 1", load_err, in_ready, jam_rst);
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if (loaded !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_no_arm ld=%0b rdy=%0b required 0 1", loaded, in_ready);
        end
        @(posedge CLK); #1;
        load_frame(1'b0, 1, 0);
        repeat (3) @(negedge CLK);
        n_checks++;
        if (loaded !== 1'b1 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_serve ld=%0b err=%0b required 1 0", loaded, load_err);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 64; i++) begin
            {W, J} = 6'(i);
            @(negedge CLK);
            expv = sb.pop_front();
            n_checks++;
            if (Cost !== expv) begin n_fail++; $display("FAIL miss_sweep idx=%0d got=%0d required=%0d", i, Cost, expv); end
            @(posedge CLK); #1;
        end
        pulse_jam_valid();
    endtask

    task automatic test_back_to_back();
        sb.delete();
        W = 3'd0; J = 3'd0;
        load_frame(1'b0, 2, 0);
        jam_valid = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (jam_rst !== 1'b1 || loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_arm_ignores_valid rst=%0b ld=%0b required 1 0", jam_rst, loaded);
        end
        @(negedge CLK);
        expv = sb.pop_front();
        n_checks++;
        if (loaded !== 1'b1 || Cost !== expv) begin
            n_fail++;
            $display("FAIL b2b_serve_entry ld=%0b cost=%0d required 1 %0d", loaded, Cost, expv);
        end
        @(posedge CLK); #1;
        jam_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (in_ready !== 1'b1 || loaded !== 1'b0 || jam_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_same_cycle_valid rdy=%0b ld=%0b rst=%0b required 1 0 1", in_ready, loaded, jam_rst);
        end
        @(posedge CLK); #1;
        sb.delete();
        load_frame(1'b1, 1, 0);
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1;
        for (int i = 0; i < 64; i++) begin
            {W, J} = 6'(i);
            @(negedge CLK);
            expv = sb.pop_front();
            n_checks++;
            if (Cost !== expv) begin n_fail++; $display("FAIL b2b_sweep idx=%0d got=%0d required=%0d", i, Cost, expv); end
            @(posedge CLK); #1;
        end
        pulse_jam_valid();
    endtask

    initial begin
        RST_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 7'd0;
        in_last   = 1'b0;
        W         = 3'd0;
        J         = 3'd0;
        jam_valid = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_load();
        test_random_valid();
        test_early_last();
        test_missing_last();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
